// File: rtl/write_control_np.sv
// rtl/write_control_np.sv - FIFO write-side controller for any depth 2..2**AW
// Pointer, fill count, hysteretic almost-full and sticky overflow with a saturating drop counter.
module write_control_np #(
    parameter int AW    = 10,
    parameter int DEPTH = 2**AW,
    parameter int OCW   = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_valid_s,
    input  logic [AW:0]   i_almostfull_lvl,
    input  logic [AW-1:0] i_af_hyst,
    input  logic          i_clr_ovf,
    input  logic [AW:0]   i_rptr,
    output logic [AW:0]   o_wptr,
    output logic [AW-1:0] o_waddr,
    output logic          o_wen,
    output logic          o_ready,
    output logic          o_full,
    output logic [AW:0]   o_wcount,
    output logic          o_almostfull,
    output logic          o_overflow,
    output logic [OCW-1:0] o_ovf_cnt
);

    localparam logic [AW:0]    DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_LOW = AW'(DEPTH-1);
    localparam logic [OCW-1:0] CNT_MAX  = '1;

    logic [AW:0]    wptr_q, wptr_d;
    logic           almostfull_q, almostfull_d;
    logic           overflow_q, overflow_d;
    logic [OCW-1:0] ovf_cnt_q, ovf_cnt_d;

    logic [AW-1:0]  w_low, r_low;
    logic           w_wrap, r_wrap;
    logic [AW:0]    wcount;
    logic           full, wen, drop;
    logic [AW+1:0]  hyst_sum;

    always_comb begin
        w_wrap = wptr_q[AW];
        w_low  = wptr_q[AW-1:0];
        r_wrap = i_rptr[AW];
        r_low  = i_rptr[AW-1:0];

        // Non-power-of-two depth: differing wrap bits mean the writer is one lap ahead.
        if (w_wrap == r_wrap) begin
            wcount = {1'b0, w_low} - {1'b0, r_low};
        end else begin
            wcount = DEPTH_W - {1'b0, r_low} + {1'b0, w_low};
        end

        full     = (wcount == DEPTH_W);
        wen      = i_rst_n & i_valid_s & ~full & ~i_flush;
        drop     = i_valid_s & full & ~i_flush;
        hyst_sum = {1'b0, wcount} + {2'b00, i_af_hyst};

        wptr_d = wptr_q;
        if (i_flush) begin
            wptr_d = '0;
        end else if (wen) begin
            if (w_low == LAST_LOW) begin
                wptr_d = {~w_wrap, {AW{1'b0}}};
            end else begin
                wptr_d = {w_wrap, w_low + AW'(1)};
            end
        end

        almostfull_d = almostfull_q;
        if (i_flush) begin
            almostfull_d = 1'b0;
        end else if (wcount >= i_almostfull_lvl) begin
            almostfull_d = 1'b1;
        end else if (hyst_sum < {1'b0, i_almostfull_lvl}) begin
            almostfull_d = 1'b0;
        end

        // A drop in the same cycle as a clear restarts the count at one.
        overflow_d = overflow_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (i_clr_ovf) begin
                ovf_cnt_d = OCW'(1);
            end else if (ovf_cnt_q != CNT_MAX) begin
                ovf_cnt_d = ovf_cnt_q + OCW'(1);
            end
        end else if (i_clr_ovf) begin
            overflow_d = 1'b0;
            ovf_cnt_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q       <= '0;
            almostfull_q <= 1'b0;
            overflow_q   <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            wptr_q       <= wptr_d;
            almostfull_q <= almostfull_d;
            overflow_q   <= overflow_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign o_wptr       = wptr_q;
    assign o_waddr      = wptr_q[AW-1:0];
    assign o_wen        = wen;
    assign o_full       = full;
    assign o_ready      = ~full;
    assign o_wcount     = wcount;
    assign o_almostfull = almostfull_q;
    assign o_overflow   = overflow_q;
    assign o_ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_write_control_np.sv
// tb/tb_write_control_np.sv - self-checking bench for write_control_np (AW=3, DEPTH=6, OCW=2)
module tb_write_control_np;

    localparam int AW    = 3;
    localparam int DEPTH = 6;
    localparam int OCW   = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           valid = 1'b0;
    logic [AW:0]    af_lvl = 4'd4;
    logic [AW-1:0]  af_hyst = 3'd2;
    logic           clr_ovf = 1'b0;
    logic [AW:0]    rptr = '0;
    logic [AW:0]    o_wptr;
    logic [AW-1:0]  o_waddr;
    logic           o_wen, o_ready, o_full, o_almostfull, o_overflow;
    logic [AW:0]    o_wcount;
    logic [OCW-1:0] o_ovf_cnt;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_low = '0;
    logic [AW-1:0] exp_pop;

    write_control_np #(.AW(AW), .DEPTH(DEPTH), .OCW(OCW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid_s(valid),
        .i_almostfull_lvl(af_lvl), .i_af_hyst(af_hyst), .i_clr_ovf(clr_ovf),
        .i_rptr(rptr), .o_wptr(o_wptr), .o_waddr(o_waddr), .o_wen(o_wen),
        .o_ready(o_ready), .o_full(o_full), .o_wcount(o_wcount),
        .o_almostfull(o_almostfull), .o_overflow(o_overflow), .o_ovf_cnt(o_ovf_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every RAM write must match the next expected address.
    always @(negedge clk) begin
        if (o_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write waddr=%0d required no write", o_waddr);
            end else begin
                exp_pop = exp_q.pop_front();
                if (o_waddr !== exp_pop) begin
                    errors++;
                    $display("FAIL waddr got=%0d exp=%0d", o_waddr, exp_pop);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_low);
            exp_low = (exp_low == 3'd5) ? 3'd0 : exp_low + 3'd1;
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (o_wptr !== 4'd0)    begin errors++; $display("FAIL rst_wptr got=%0d exp=0", o_wptr); end
        checks++; if (o_wen !== 1'b0)     begin errors++; $display("FAIL rst_wen got=%b exp=0", o_wen); end
        checks++; if (o_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
        checks++; if (o_wcount !== 4'd0)  begin errors++; $display("FAIL rst_wcount got=%0d exp=0", o_wcount); end
        checks++; if ({o_full, o_almostfull, o_overflow, o_ovf_cnt} !== 5'b0)
            begin errors++; $display("FAIL rst_flags got=%b exp=00000", {o_full, o_almostfull, o_overflow, o_ovf_cnt}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        rptr = '0;
        push_writes(6);
        checks++; if (o_wptr !== 4'b1000) begin errors++; $display("FAIL fill_wptr got=%b exp=1000", o_wptr); end
        checks++; if (o_wcount !== 4'd6)  begin errors++; $display("FAIL fill_wcount got=%0d exp=6", o_wcount); end
        checks++; if (o_full !== 1'b1 || o_ready !== 1'b0)
            begin errors++; $display("FAIL fill_full got=%b%b exp=10", o_full, o_ready); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fill_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) begin
            valid = 1'b1;
            #1;
            checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL ovf_wen k=%0d got=%b exp=0", k, o_wen); end
            step();
            checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag k=%0d got=%b exp=1", k, o_overflow); end
            checks++; if (o_ovf_cnt !== ((k > 3) ? 2'd3 : 2'(k)))
                begin errors++; $display("FAIL ovf_cnt k=%0d got=%0d exp=%0d", k, o_ovf_cnt, (k > 3) ? 3 : k); end
        end
        clr_ovf = 1'b1;
        step();
        valid = 1'b0;
        clr_ovf = 1'b0;
        checks++; if ({o_overflow, o_ovf_cnt} !== 3'b101)
            begin errors++; $display("FAIL ovf_clr_drop got=%b exp=101", {o_overflow, o_ovf_cnt}); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if ({o_overflow, o_ovf_cnt} !== 3'b000)
            begin errors++; $display("FAIL ovf_clr got=%b exp=000", {o_overflow, o_ovf_cnt}); end
        valid = 1'b1;
        step();
        valid = 1'b0;
        checks++; if ({o_overflow, o_ovf_cnt} !== 3'b101)
            begin errors++; $display("FAIL ovf_redrop got=%b exp=101", {o_overflow, o_ovf_cnt}); end
    endtask

    task automatic test_wrap();
        flush = 1'b1;
        step();
        flush = 1'b0;
        rptr = '0;
        exp_low = '0;
        push_writes(5);
        checks++; if (o_wptr !== 4'b0101) begin errors++; $display("FAIL wrap_pre got=%b exp=0101", o_wptr); end
        rptr = 4'b0101;
        #1;
        checks++; if (o_wcount !== 4'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", o_wcount); end
        push_writes(3);
        checks++; if (o_wptr !== 4'b1010) begin errors++; $display("FAIL wrap_wptr got=%b exp=1010", o_wptr); end
        checks++; if (o_wcount !== 4'd3)  begin errors++; $display("FAIL wrap_wcount got=%0d exp=3", o_wcount); end
        rptr = 4'b1010;
        #1;
        checks++; if (o_wcount !== 4'd0)  begin errors++; $display("FAIL wrap_caught_up got=%0d exp=0", o_wcount); end
    endtask

    task automatic test_hysteresis();
        flush = 1'b1;
        step();
        flush = 1'b0;
        rptr = '0;
        exp_low = '0;
        push_writes(4);
        checks++; if (o_wcount !== 4'd4 || o_almostfull !== 1'b0)
            begin errors++; $display("FAIL af_lag got=%0d/%b exp=4/0", o_wcount, o_almostfull); end
        step();
        checks++; if (o_almostfull !== 1'b1) begin errors++; $display("FAIL af_rise got=%b exp=1", o_almostfull); end
        rptr = 4'd1;
        step();
        checks++; if (o_wcount !== 4'd3 || o_almostfull !== 1'b1)
            begin errors++; $display("FAIL af_hold3 got=%0d/%b exp=3/1", o_wcount, o_almostfull); end
        rptr = 4'd2;
        step();
        checks++; if (o_almostfull !== 1'b1) begin errors++; $display("FAIL af_hold2 got=%b exp=1", o_almostfull); end
        rptr = 4'd3;
        #1;
        checks++; if (o_wcount !== 4'd1 || o_almostfull !== 1'b1)
            begin errors++; $display("FAIL af_pre_fall got=%0d/%b exp=1/1", o_wcount, o_almostfull); end
        step();
        checks++; if (o_almostfull !== 1'b0) begin errors++; $display("FAIL af_fall got=%b exp=0", o_almostfull); end
    endtask

    task automatic test_flush();
        push_writes(4);
        step();
        checks++; if (o_wcount !== 4'd5 || o_almostfull !== 1'b1)
            begin errors++; $display("FAIL flush_pre got=%0d/%b exp=5/1", o_wcount, o_almostfull); end
        valid = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL flush_wen got=%b exp=0", o_wen); end
        step();
        valid = 1'b0;
        flush = 1'b0;
        rptr = '0;
        exp_low = '0;
        checks++; if (o_wptr !== 4'd0 || o_almostfull !== 1'b0)
            begin errors++; $display("FAIL flush_state got=%b/%b exp=0000/0", o_wptr, o_almostfull); end
        checks++; if ({o_overflow, o_ovf_cnt} !== 3'b101)
            begin errors++; $display("FAIL flush_keeps_ovf got=%b exp=101", {o_overflow, o_ovf_cnt}); end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exp_low);
            exp_low = exp_low + 3'd1;
            valid = 1'b1;
            step();
        end
        checks++; if (o_wcount !== 4'd3) begin errors++; $display("FAIL burst_count got=%0d exp=3", o_wcount); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_wptr !== 4'd0 || o_waddr !== 3'd0 || o_wen !== 1'b0)
            begin errors++; $display("FAIL mid_rst_ptr got=%b/%0d/%b exp=0000/0/0", o_wptr, o_waddr, o_wen); end
        checks++; if ({o_full, o_ready, o_wcount, o_almostfull, o_overflow, o_ovf_cnt} !== 10'b01_0000_0_0_00)
            begin errors++; $display("FAIL mid_rst_flags got=%b exp=0100000000", {o_full, o_ready, o_wcount, o_almostfull, o_overflow, o_ovf_cnt}); end
        step();
        rst_n = 1'b1;
        exp_low = '0;
        push_writes(1);
        checks++; if (o_wptr !== 4'd1 || exp_q.size() != 0)
            begin errors++; $display("FAIL post_rst_write got=%b/%0d exp=0001/0", o_wptr, exp_q.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_hysteresis();
        test_flush();
        test_reset_mid_burst();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
